// File: rtl/ufm_rom_loader.sv
`timescale 1ns/1ps
// ufm_rom_loader
// Copies a ROM image from the on-chip user flash (UFM) into a byte-wide RAM.
// On a start pulse it polls the flash CSR status until idle. It then issues
// 2-word Avalon-MM read bursts. Each returned 32-bit word is written to RAM
// one byte per cycle, least significant byte first.
//
// Ports:
//   clock, reset            system clock, synchronous active-high reset
//   start / busy / done     control: start pulse, copy in progress, completion pulse
//   avmm_data_*             UFM data port master (13-bit word address, burst of 2)
//   avmm_csr_*              UFM CSR port master (status register, busy field in [1:0])
//   ram_addr/ram_data/ram_we  byte write port of the shadow RAM
//   checksum                only with UFM_LOADER_CHECKSUM_EN: 16-bit sum of the
//                           bytes written; valid from done until the next start
//
// Optional feature macro: UFM_LOADER_CHECKSUM_EN
module ufm_rom_loader #(
  parameter int unsigned WORD_BASE  = 0,
  parameter int unsigned WORD_COUNT = 4096,
  parameter int unsigned RAM_AW     = 14
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [12:0]       avmm_data_addr,
  output logic              avmm_data_read,
  output logic [1:0]        avmm_data_burstcount,
  input  logic [31:0]       avmm_data_readdata,
  input  logic              avmm_data_waitrequest,
  input  logic              avmm_data_readdatavalid,
  output logic              avmm_csr_addr,
  output logic              avmm_csr_read,
  input  logic [31:0]       avmm_csr_readdata,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [7:0]        ram_data,
  output logic              ram_we
`ifdef UFM_LOADER_CHECKSUM_EN
  ,
  output logic [15:0]       checksum
`endif
);

  localparam int unsigned FLASH_AW  = 13;
  localparam int unsigned CNT_W     = $clog2(WORD_COUNT + 1);
  localparam logic [FLASH_AW-1:0] BASE_ADDR = FLASH_AW'(WORD_BASE);
  localparam logic [CNT_W-1:0]    LAST_CNT  = CNT_W'(WORD_COUNT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CSR_RD,
    S_CSR_CHK,
    S_BURST,
    S_RECV,
    S_UNPACK,
    S_DONE
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   words_done;
  logic [CNT_W-1:0]   words_next;
  logic               second_beat;
  logic [31:0]        word0;
  logic [55:0]        unpack_sr;   // remaining bytes of the pair after the one on ram_data
  logic [2:0]         byte_cnt;

  // Only the status busy field of the CSR is meaningful here.
  logic unused_csr_bits;
  assign unused_csr_bits = ^avmm_csr_readdata[31:2];

  assign avmm_data_burstcount = 2'd2;
  assign avmm_csr_addr        = 1'b0;
  assign words_next           = words_done + CNT_W'(2);

  // Copy sequencer; all bus and RAM strobes are registered here.
  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= S_IDLE;
      busy           <= 1'b0;
      done           <= 1'b0;
      avmm_data_read <= 1'b0;
      avmm_csr_read  <= 1'b0;
      ram_we         <= 1'b0;
      avmm_data_addr <= BASE_ADDR;
      ram_addr       <= '0;
      ram_data       <= '0;
      words_done     <= '0;
      second_beat    <= 1'b0;
      word0          <= '0;
      unpack_sr      <= '0;
      byte_cnt       <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            busy           <= 1'b1;
            avmm_data_addr <= BASE_ADDR;
            ram_addr       <= '0;
            words_done     <= '0;
            avmm_csr_read  <= 1'b1;
            state          <= S_CSR_RD;
          end
        end

        S_CSR_RD: begin
          avmm_csr_read <= 1'b0;
          state         <= S_CSR_CHK;
        end

        // Read data arrives the cycle after the strobe.
        S_CSR_CHK: begin
          if (avmm_csr_readdata[1:0] == 2'b00) begin
            avmm_data_read <= 1'b1;
            state          <= S_BURST;
          end else begin
            avmm_csr_read <= 1'b1;
            state         <= S_CSR_RD;
          end
        end

        // Command held stable until the slave drops waitrequest.
        S_BURST: begin
          if (!avmm_data_waitrequest) begin
            avmm_data_read <= 1'b0;
            second_beat    <= 1'b0;
            state          <= S_RECV;
          end
        end

        S_RECV: begin
          if (avmm_data_readdatavalid) begin
            if (!second_beat) begin
              word0       <= avmm_data_readdata;
              second_beat <= 1'b1;
            end else begin
              // First byte goes out immediately; the other seven queue in the shifter.
              unpack_sr   <= {avmm_data_readdata, word0[31:8]};
              ram_data    <= word0[7:0];
              ram_we      <= 1'b1;
              byte_cnt    <= 3'd0;
              second_beat <= 1'b0;
              state       <= S_UNPACK;
            end
          end
        end

        S_UNPACK: begin
          ram_addr <= ram_addr + RAM_AW'(1);
          if (byte_cnt == 3'd7) begin
            ram_we         <= 1'b0;
            avmm_data_addr <= avmm_data_addr + FLASH_AW'(2);
            words_done     <= words_next;
            if (words_next == LAST_CNT) begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= S_DONE;
            end else begin
              avmm_data_read <= 1'b1;
              state          <= S_BURST;
            end
          end else begin
            ram_data  <= unpack_sr[7:0];
            unpack_sr <= {8'h00, unpack_sr[55:8]};
            byte_cnt  <= byte_cnt + 3'd1;
          end
        end

        S_DONE: state <= S_IDLE;

        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef UFM_LOADER_CHECKSUM_EN
  // Running byte sum; cleared when a copy is accepted.
  always_ff @(posedge clock) begin
    if (reset) begin
      checksum <= '0;
    end else if (state == S_IDLE && start) begin
      checksum <= '0;
    end else if (ram_we) begin
      checksum <= checksum + 16'(ram_data);
    end
  end
`endif

endmodule

// File: tb/tb_ufm_rom_loader.sv
`timescale 1ns/1ps
// Scoreboard bench for ufm_rom_loader: flash/CSR slave models plus a RAM
// write monitor that pops expected bytes pushed by the stimulus.
module tb_ufm_rom_loader;

  localparam int unsigned WORD_BASE  = 0;
  localparam int unsigned WORD_COUNT = 4;
  localparam int unsigned RAM_AW     = 14;

  logic              clock = 1'b0;
  logic              reset;
  logic              start;
  logic              busy;
  logic              done;
  logic [12:0]       avmm_data_addr;
  logic              avmm_data_read;
  logic [1:0]        avmm_data_burstcount;
  logic [31:0]       avmm_data_readdata;
  logic              avmm_data_waitrequest;
  logic              avmm_data_readdatavalid;
  logic              avmm_csr_addr;
  logic              avmm_csr_read;
  logic [31:0]       avmm_csr_readdata;
  logic [RAM_AW-1:0] ram_addr;
  logic [7:0]        ram_data;
  logic              ram_we;
`ifdef UFM_LOADER_CHECKSUM_EN
  logic [15:0]       checksum;
`endif

  always #5 clock = ~clock;

  ufm_rom_loader #(
    .WORD_BASE (WORD_BASE),
    .WORD_COUNT(WORD_COUNT),
    .RAM_AW    (RAM_AW)
  ) dut (
    .clock                  (clock),
    .reset                  (reset),
    .start                  (start),
    .busy                   (busy),
    .done                   (done),
    .avmm_data_addr         (avmm_data_addr),
    .avmm_data_read         (avmm_data_read),
    .avmm_data_burstcount   (avmm_data_burstcount),
    .avmm_data_readdata     (avmm_data_readdata),
    .avmm_data_waitrequest  (avmm_data_waitrequest),
    .avmm_data_readdatavalid(avmm_data_readdatavalid),
    .avmm_csr_addr          (avmm_csr_addr),
    .avmm_csr_read          (avmm_csr_read),
    .avmm_csr_readdata      (avmm_csr_readdata),
    .ram_addr               (ram_addr),
    .ram_data               (ram_data),
    .ram_we                 (ram_we)
`ifdef UFM_LOADER_CHECKSUM_EN
    ,
    .checksum               (checksum)
`endif
  );

  typedef struct packed {
    logic [RAM_AW-1:0] addr;
    logic [7:0]        data;
  } ram_wr_t;

  ram_wr_t     exp_wr_q[$];
  logic [12:0] exp_burst_q[$];
  logic [31:0] flash [8192];

  int checks      = 0;
  int errors      = 0;
  int done_cnt    = 0;
  int csr_polls   = 0;
  int busy_polls  = 0;
  int stall_cyc   = 0;
  int gap_cyc     = 0;
  logic [15:0] exp_sum = 16'h0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // RAM write and done monitor.
  initial begin : ram_monitor
    forever begin
      @(posedge clock); #1;
      if (ram_we) begin
        ram_wr_t e;
        if (exp_wr_q.size() == 0) begin
          check("ram_unexpected_write", 64'(ram_addr), 64'hFFFF);
        end else begin
          e = exp_wr_q.pop_front();
          check("ram_addr", 64'(ram_addr), 64'(e.addr));
          check("ram_data", 64'(ram_data), 64'(e.data));
        end
      end
      if (done) begin
        done_cnt++;
`ifdef UFM_LOADER_CHECKSUM_EN
        check("checksum_at_done", 64'(checksum), 64'(exp_sum));
`endif
      end
    end
  end

  // CSR slave: reports busy for busy_polls reads, then idle (upper bits junk).
  initial begin : csr_slave
    avmm_csr_readdata = 32'h0;
    forever begin
      @(posedge clock); #1;
      if (avmm_csr_read) begin
        csr_polls++;
        avmm_csr_readdata = (csr_polls <= busy_polls) ? 32'h0000_0001 : 32'hA5A5_A5A4;
      end
    end
  end

  // Flash data slave with programmable stall and readdatavalid gaps.
  initial begin : flash_slave
    logic [12:0] a;
    avmm_data_waitrequest   = 1'b0;
    avmm_data_readdatavalid = 1'b0;
    avmm_data_readdata      = 32'hDEAD_BEEF;
    forever begin
      @(posedge clock); #1;
      if (avmm_data_read) begin
        a = avmm_data_addr;
        check("csr_polls_before_read", 64'(csr_polls), 64'(busy_polls + 1));
        if (exp_burst_q.size() == 0) check("burst_unexpected", 64'(a), 64'h1FFFF);
        else check("burst_addr", 64'(a), 64'(exp_burst_q.pop_front()));
        check("burstcount", 64'(avmm_data_burstcount), 64'd2);
        avmm_data_waitrequest = (stall_cyc != 0);
        for (int i = 1; i <= stall_cyc; i++) begin
          @(posedge clock); #1;
          check("hold_addr", 64'(avmm_data_addr), 64'(a));
          check("hold_read", 64'(avmm_data_read), 64'd1);
          check("hold_burstcount", 64'(avmm_data_burstcount), 64'd2);
          if (i == stall_cyc) avmm_data_waitrequest = 1'b0;
        end
        @(posedge clock); #1;
        check("read_drop", 64'(avmm_data_read), 64'd0);
        for (int k = 0; k < 2; k++) begin
          repeat (gap_cyc) begin @(posedge clock); #1; end
          avmm_data_readdatavalid = 1'b1;
          avmm_data_readdata      = flash[13'(a + 13'(k))];
          @(posedge clock); #1;
          avmm_data_readdatavalid = 1'b0;
          avmm_data_readdata      = 32'hDEAD_BEEF;
        end
      end
    end
  end

  task automatic load_flash(input logic [31:0] w0, w1, w2, w3);
    flash[WORD_BASE + 0] = w0;
    flash[WORD_BASE + 1] = w1;
    flash[WORD_BASE + 2] = w2;
    flash[WORD_BASE + 3] = w3;
  endtask

  // Queue the expected RAM bytes, burst addresses and byte sum of a full copy.
  task automatic push_expected();
    ram_wr_t     e;
    logic [31:0] w;
    exp_sum = 16'h0;
    for (int wi = 0; wi < int'(WORD_COUNT); wi++) begin
      if (wi % 2 == 0) exp_burst_q.push_back(13'(WORD_BASE + wi));
      w = flash[WORD_BASE + wi];
      for (int b = 0; b < 4; b++) begin
        e.addr = RAM_AW'(wi * 4 + b);
        e.data = w[8*b +: 8];
        exp_sum = exp_sum + 16'(e.data);
        exp_wr_q.push_back(e);
      end
    end
  endtask

  task automatic pulse_start();
    @(posedge clock); #1; start = 1'b1;
    @(posedge clock); #1; start = 1'b0;
  endtask

  task automatic wait_ram_we(input string name);
    int cyc = 0;
    while (!ram_we && cyc < 2000) begin @(posedge clock); #1; cyc++; end
    if (!ram_we) check(name, 64'd0, 64'd1);
  endtask

  task automatic run_copy(input string tag, input int bp, input int st, input int gp,
                          input bit mid_start);
    int cyc = 0;
    busy_polls = bp; stall_cyc = st; gap_cyc = gp;
    csr_polls = 0; done_cnt = 0;
    push_expected();
    pulse_start();
    check({tag, "_busy_after_start"}, 64'(busy), 64'd1);
    if (mid_start) begin
      wait_ram_we({tag, "_ram_we_timeout"});
      pulse_start();
    end
    while (done_cnt == 0 && cyc < 5000) begin @(posedge clock); #1; cyc++; end
    if (done_cnt == 0) check({tag, "_done_timeout"}, 64'd0, 64'd1);
    repeat (4) begin @(posedge clock); #1; end
    check({tag, "_done_count"}, 64'(done_cnt), 64'd1);
    check({tag, "_busy_after_done"}, 64'(busy), 64'd0);
    check({tag, "_ram_addr_end"}, 64'(ram_addr), 64'(4 * WORD_COUNT));
    check({tag, "_bytes_left"}, 64'(exp_wr_q.size()), 64'd0);
    check({tag, "_bursts_left"}, 64'(exp_burst_q.size()), 64'd0);
    check({tag, "_csr_polls"}, 64'(csr_polls), 64'(bp + 1));
  endtask

  initial begin : stimulus
    int saved_done;
    reset = 1'b1;
    start = 1'b0;
    for (int i = 0; i < 8192; i++) flash[i] = 32'h0;
    repeat (3) begin @(posedge clock); #1; end
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_data_read", 64'(avmm_data_read), 64'd0);
    check("rst_csr_read", 64'(avmm_csr_read), 64'd0);
    check("rst_ram_we", 64'(ram_we), 64'd0);
    check("rst_data_addr", 64'(avmm_data_addr), 64'(WORD_BASE));
    check("rst_burstcount", 64'(avmm_data_burstcount), 64'd2);
    check("rst_csr_addr", 64'(avmm_csr_addr), 64'd0);
    check("rst_ram_addr", 64'(ram_addr), 64'd0);
    check("rst_ram_data", 64'(ram_data), 64'd0);
    reset = 1'b0;
    repeat (2) begin @(posedge clock); #1; end

    // Basic copy, idle CSR, no stalls.
    load_flash(32'h4433_2211, 32'h8877_6655, 32'hCAFE_BABE, 32'h0123_4567);
    run_copy("basic", 0, 0, 0, 1'b0);

    // CSR busy for three polls.
    run_copy("csr_poll", 3, 0, 0, 1'b0);

    // Waitrequest stalls and readdatavalid gaps.
    load_flash(32'h1020_3040, 32'h5060_7080, 32'h90A0_B0C0, 32'hD0E0_F000);
    run_copy("stall", 0, 5, 3, 1'b0);

    // Reset two cycles after the first RAM write aborts the copy.
    busy_polls = 0; stall_cyc = 0; gap_cyc = 0; csr_polls = 0;
    push_expected();
    pulse_start();
    wait_ram_we("abort_ram_we_timeout");
    repeat (2) begin @(posedge clock); #1; end
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    check("abort_ram_we", 64'(ram_we), 64'd0);
    check("abort_data_read", 64'(avmm_data_read), 64'd0);
    check("abort_csr_read", 64'(avmm_csr_read), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_ram_addr", 64'(ram_addr), 64'd0);
    exp_wr_q.delete();
    exp_burst_q.delete();
    saved_done = done_cnt;
    repeat (20) begin @(posedge clock); #1; end
    check("abort_no_done", 64'(done_cnt), 64'(saved_done));
    run_copy("restart", 0, 0, 0, 1'b0);

    // Second start during the copy is ignored.
    run_copy("mid_start", 1, 2, 1, 1'b1);

    // Byte sum wrap case.
    load_flash(32'hFFFF_FFFF, 32'h0000_0001, 32'h0, 32'h0);
    run_copy("sum", 0, 0, 0, 1'b0);
`ifdef UFM_LOADER_CHECKSUM_EN
    check("checksum_value", 64'(checksum), 64'h03FD);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
